// File: rtl/bbox_pkg.sv
// Shared definitions for the bounding-box message scheduler.
// The HDR state exists only when BBOX_MSG_HEADER_EN is defined.
package bbox_pkg;

`ifdef BBOX_MSG_HEADER_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    HDR   = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1
  } state_t;
`endif

  // Default coordinate width of every bounding-box edge.
  localparam int COORD_W_DEF = 11;

  // Upper half of the header word.
  localparam logic [15:0] HDR_MAGIC = 16'h4242;

  // Message word layout: empty flag, x field, y field.
  localparam int EMPTY_BIT = 31;
  localparam int X_LSB     = 16;
  localparam int Y_LSB     = 0;
  localparam int FIELD_W   = 11;

endpackage

// File: rtl/bbox_word_fmt.sv
// Packs one colour's bounding box into a 32-bit message word.
// corner=0 selects the top-left point, corner=1 the bottom-right point.
module bbox_word_fmt
  import bbox_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEF
) (
  input  logic [COORD_W-1:0] xmin,
  input  logic [COORD_W-1:0] ymin,
  input  logic [COORD_W-1:0] xmax,
  input  logic [COORD_W-1:0] ymax,
  input  logic               corner,
  output logic [31:0]        word
);

  logic               empty;
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;

  // An inverted box on either axis means the colour was not seen this frame.
  always_comb begin
    empty = (xmin > xmax) || (ymin > ymax);
    x     = corner ? xmax : xmin;
    y     = corner ? ymax : ymin;
    word  = '0;
    word[EMPTY_BIT]        = empty;
    word[X_LSB +: COORD_W] = x;
    word[Y_LSB +: COORD_W] = y;
  end

endmodule

// File: rtl/bbox_msg_scheduler.sv
// Bounding-box message scheduler: every N frames, writes one burst of
// per-colour corner words into a downstream FIFO when there is room.
// Optional feature: define BBOX_MSG_HEADER_EN to prefix each burst with a
// header word carrying a wrapping 8-bit sequence number.
module bbox_msg_scheduler
  import bbox_pkg::*;
#(
  parameter int NUM_COLOURS  = 6,
  parameter int COORD_W      = COORD_W_DEF,
  parameter int FIFO_DEPTH   = 256,
  parameter int MSG_INTERVAL = 6
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           enable,
  input  logic                           frame_done,
  input  logic [NUM_COLOURS*COORD_W-1:0] bb_xmin,
  input  logic [NUM_COLOURS*COORD_W-1:0] bb_ymin,
  input  logic [NUM_COLOURS*COORD_W-1:0] bb_xmax,
  input  logic [NUM_COLOURS*COORD_W-1:0] bb_ymax,
  input  logic [7:0]                     interval_cfg,
  input  logic [7:0]                     fifo_usedw,
  input  logic                           msg_flush,
  output logic                           fifo_wr,
  output logic [31:0]                    fifo_data,
  output logic                           busy,
  output logic [15:0]                    frames_skipped
);

`ifdef BBOX_MSG_HEADER_EN
  localparam int WORDS = 2*NUM_COLOURS + 1;
`else
  localparam int WORDS = 2*NUM_COLOURS;
`endif

  localparam int              IDX_W    = (2*NUM_COLOURS > 1) ? $clog2(2*NUM_COLOURS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(2*NUM_COLOURS - 1);
  // Highest occupancy that still leaves space for a whole burst.
  localparam logic [31:0]     ROOM_MAX = 32'(FIFO_DEPTH - 1 - WORDS);

  state_t                         state;
  state_t                         state_nxt;
  logic [IDX_W-1:0]               idx;
  logic [7:0]                     frame_cnt;
  logic [7:0]                     eff_interval;
  logic [7:0]                     reload_val;
  logic [15:0]                    skip_cnt;
  logic                           room_ok;
  logic                           start;
  logic                           skip;
  logic                           last_word;
  logic                           active;
  logic [NUM_COLOURS*COORD_W-1:0] snap_xmin;
  logic [NUM_COLOURS*COORD_W-1:0] snap_ymin;
  logic [NUM_COLOURS*COORD_W-1:0] snap_xmax;
  logic [NUM_COLOURS*COORD_W-1:0] snap_ymax;
  logic [COORD_W-1:0]             sel_xmin;
  logic [COORD_W-1:0]             sel_ymin;
  logic [COORD_W-1:0]             sel_xmax;
  logic [COORD_W-1:0]             sel_ymax;
  logic [31:0]                    word_colour;
  logic [31:0]                    word_out;
  int                             col;

`ifdef BBOX_MSG_HEADER_EN
  logic [7:0]                     seq;
`endif

  // Interval 0 falls back to the build-time default.
  always_comb begin
    eff_interval = (interval_cfg == 8'd0) ? 8'(MSG_INTERVAL) : interval_cfg;
    reload_val   = eff_interval - 8'd1;
    room_ok      = ({24'd0, fifo_usedw} <= ROOM_MAX);
    last_word    = (idx == LAST_IDX);
  end

  // State register; reset abandons any burst in flight.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state, start/skip decisions and FIFO-facing outputs.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    skip      = 1'b0;
    case (state)
      IDLE: begin
        if (frame_done && (frame_cnt == 8'd0) && enable) begin
          if (!room_ok) begin
            skip = 1'b1;
          end else if (!msg_flush) begin
            start = 1'b1;
`ifdef BBOX_MSG_HEADER_EN
            state_nxt = HDR;
`else
            state_nxt = BURST;
`endif
          end
        end
      end
`ifdef BBOX_MSG_HEADER_EN
      HDR: begin
        state_nxt = BURST;
      end
`endif
      BURST: begin
        if (last_word) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    // A flush wins over everything, including a start in IDLE.
    if (msg_flush) begin
      state_nxt = IDLE;
    end

    active   = (state != IDLE);
    busy     = active;
    fifo_wr  = active && !msg_flush;
    word_out = word_colour;
`ifdef BBOX_MSG_HEADER_EN
    if (state == HDR) begin
      word_out = {HDR_MAGIC, seq, 8'(NUM_COLOURS)};
    end
`endif
    fifo_data      = fifo_wr ? word_out : 32'd0;
    frames_skipped = skip_cnt;
  end

  // Frame countdown: a start reloads it, any other frame_done counts down to 0.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      frame_cnt <= 8'd0;
    end else if (start) begin
      frame_cnt <= reload_val;
    end else if (frame_done && (frame_cnt != 8'd0)) begin
      frame_cnt <= frame_cnt - 8'd1;
    end
  end

  // Saturating count of frames lost to a full FIFO.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      skip_cnt <= 16'd0;
    end else if (skip && (skip_cnt != 16'hFFFF)) begin
      skip_cnt <= skip_cnt + 16'd1;
    end
  end

  // Word index within the colour section; cleared whenever not streaming.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      idx <= '0;
    end else if ((state == BURST) && (state_nxt == BURST)) begin
      idx <= idx + IDX_W'(1);
    end else begin
      idx <= '0;
    end
  end

`ifdef BBOX_MSG_HEADER_EN
  // Sequence number advances only when a burst runs to its last word.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      seq <= 8'd0;
    end else if ((state == BURST) && last_word && !msg_flush) begin
      seq <= seq + 8'd1;
    end
  end
`endif

  // Freeze the boxes at the start decision so the burst is self-consistent.
  always_ff @(posedge clk) begin
    if (start) begin
      snap_xmin <= bb_xmin;
      snap_ymin <= bb_ymin;
      snap_xmax <= bb_xmax;
      snap_ymax <= bb_ymax;
    end
  end

  // Two words per colour: even index is top-left, odd is bottom-right.
  always_comb begin
    col      = int'(idx) / 2;
    sel_xmin = snap_xmin[col*COORD_W +: COORD_W];
    sel_ymin = snap_ymin[col*COORD_W +: COORD_W];
    sel_xmax = snap_xmax[col*COORD_W +: COORD_W];
    sel_ymax = snap_ymax[col*COORD_W +: COORD_W];
  end

  bbox_word_fmt #(
    .COORD_W (COORD_W)
  ) u_word_fmt (
    .xmin   (sel_xmin),
    .ymin   (sel_ymin),
    .xmax   (sel_xmax),
    .ymax   (sel_ymax),
    .corner (idx[0]),
    .word   (word_colour)
  );

endmodule

// File: tb/tb_bbox_msg_scheduler.sv
// Self-checking bench for bbox_msg_scheduler (default parameters).
// Build with BBOX_MSG_HEADER_EN defined to exercise the header variant.
module tb_bbox_msg_scheduler;

  localparam int NC = 6;
  localparam int CW = 11;
`ifdef BBOX_MSG_HEADER_EN
  localparam int HOFF = 1;
`else
  localparam int HOFF = 0;
`endif
  localparam int WORDS = 2*NC + HOFF;
  localparam int ROOM  = 256 - 1 - WORDS;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              enable;
  logic              frame_done;
  logic [NC*CW-1:0]  bb_xmin;
  logic [NC*CW-1:0]  bb_ymin;
  logic [NC*CW-1:0]  bb_xmax;
  logic [NC*CW-1:0]  bb_ymax;
  logic [7:0]        interval_cfg;
  logic [7:0]        fifo_usedw;
  logic              msg_flush;
  logic              fifo_wr;
  logic [31:0]       fifo_data;
  logic              busy;
  logic [15:0]       frames_skipped;

  always #5 clk = ~clk;

  bbox_msg_scheduler dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .enable         (enable),
    .frame_done     (frame_done),
    .bb_xmin        (bb_xmin),
    .bb_ymin        (bb_ymin),
    .bb_xmax        (bb_xmax),
    .bb_ymax        (bb_ymax),
    .interval_cfg   (interval_cfg),
    .fifo_usedw     (fifo_usedw),
    .msg_flush      (msg_flush),
    .fifo_wr        (fifo_wr),
    .fifo_data      (fifo_data),
    .busy           (busy),
    .frames_skipped (frames_skipped)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  // The pending burst is a queue of words; idle means the queue is empty.
  logic [31:0] mq[$];
  logic [31:0] wlog[$];
  int          m_cnt  = 0;
  int          m_skip = 0;
  int          m_seq  = 0;
  bit          m_live = 1'b0;

  function automatic logic [31:0] colour_word(input int c, input bit br);
    int x0, y0, x1, y1;
    logic [31:0] w;
    x0 = int'(bb_xmin[c*CW +: CW]);
    y0 = int'(bb_ymin[c*CW +: CW]);
    x1 = int'(bb_xmax[c*CW +: CW]);
    y1 = int'(bb_ymax[c*CW +: CW]);
    w = 32'((br ? x1 : x0) * 65536 + (br ? y1 : y0));
    w[31] = (x0 > x1) || (y0 > y1);
    return w;
  endfunction

  always @(posedge clk) begin : model
    bit idle;
    if (!reset_n) begin
      mq.delete();
      m_cnt  = 0;
      m_skip = 0;
      m_seq  = 0;
      m_live = 1'b1;
    end else begin
      idle = (mq.size() == 0);
      if (!idle) begin
        if (msg_flush) mq.delete();
        else begin
          void'(mq.pop_front());
          if (mq.size() == 0) m_seq = (m_seq + 1) % 256;
        end
      end
      if (frame_done) begin
        if (idle && m_cnt == 0 && enable) begin
          if (int'(fifo_usedw) > ROOM) begin
            if (m_skip < 65535) m_skip = m_skip + 1;
          end else if (!msg_flush) begin
            if (HOFF != 0) mq.push_back({16'h4242, 8'(m_seq), 8'(NC)});
            for (int c = 0; c < NC; c++) begin
              mq.push_back(colour_word(c, 1'b0));
              mq.push_back(colour_word(c, 1'b1));
            end
            m_cnt = ((interval_cfg == 8'd0) ? 6 : int'(interval_cfg)) - 1;
          end
        end else if (m_cnt > 0) begin
          m_cnt = m_cnt - 1;
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model, plus a log of writes.
  always @(negedge clk) begin : cmp
    logic exp_wr;
    if (m_live) begin
      exp_wr = (mq.size() != 0) && !msg_flush;
      check("fifo_wr", 32'(fifo_wr), 32'(exp_wr));
      check("fifo_data", fifo_data, exp_wr ? mq[0] : 32'h0);
      check("busy", 32'(busy), 32'(mq.size() != 0));
      check("frames_skipped", 32'(frames_skipped), 32'(m_skip));
      if (fifo_wr) wlog.push_back(fifo_data);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    frame_done = 1'b1;
    step(1);
    frame_done = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step(2);
    reset_n = 1'b1;
    step(1);
    wlog.delete();
  endtask

  task automatic set_box(input int c, input int x0, input int y0, input int x1, input int y1);
    bb_xmin[c*CW +: CW] = CW'(x0);
    bb_ymin[c*CW +: CW] = CW'(y0);
    bb_xmax[c*CW +: CW] = CW'(x1);
    bb_ymax[c*CW +: CW] = CW'(y1);
  endtask

  initial begin
    reset_n      = 1'b0;
    enable       = 1'b1;
    frame_done   = 1'b0;
    interval_cfg = 8'd0;
    fifo_usedw   = 8'd0;
    msg_flush    = 1'b0;
    for (int c = 0; c < NC; c++) set_box(c, c + 1, c + 2, 100 + c, 200 + c);
    step(3);
    reset_n = 1'b1;
    step(1);
    check("reset_fifo_wr", 32'(fifo_wr), 32'd0);
    check("reset_fifo_data", fifo_data, 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_skipped", 32'(frames_skipped), 32'd0);

    // Default interval: bursts on pulses 1 and 7 only.
    wlog.delete();
    for (int p = 1; p <= 7; p++) begin
      wlog.delete();
      pulse();
      step(WORDS + 2);
      check($sformatf("interval_pulse%0d_writes", p), 32'(wlog.size()),
            (p == 1 || p == 7) ? 32'(WORDS) : 32'd0);
    end

    // Word formatting and snapshot isolation.
    do_reset();
    set_box(2, 10, 20, 30, 40);
    set_box(4, 639, 5, 0, 6);
    pulse();
    for (int c = 0; c < NC; c++) set_box(c, 7, 7, 3, 3);
    step(WORDS + 2);
    check("fmt_writes", 32'(wlog.size()), 32'(WORDS));
    if (wlog.size() == WORDS) begin
      check("fmt_c0_tl", wlog[HOFF + 0], 32'h00010002);
      check("fmt_c2_tl", wlog[HOFF + 4], 32'h000A0014);
      check("fmt_c2_br", wlog[HOFF + 5], 32'h001E0028);
      check("fmt_c4_tl_empty", wlog[HOFF + 8], 32'h827F0005);
      check("fmt_c4_br_empty", wlog[HOFF + 9], 32'h80000006);
    end
    for (int c = 0; c < NC; c++) set_box(c, c + 1, c + 2, 100 + c, 200 + c);

    // FIFO room boundary: one over skips, exact fit starts.
    do_reset();
    fifo_usedw = 8'(ROOM + 1);
    pulse();
    step(WORDS + 2);
    check("room_skip_count", 32'(frames_skipped), 32'd1);
    check("room_skip_writes", 32'(wlog.size()), 32'd0);
    fifo_usedw = 8'(ROOM);
    wlog.delete();
    pulse();
    step(WORDS + 2);
    check("room_fit_writes", 32'(wlog.size()), 32'(WORDS));
    check("room_fit_skipped", 32'(frames_skipped), 32'd1);
    fifo_usedw = 8'd0;

    // Flush coinciding with a start blocks it without reloading the counter.
    do_reset();
    msg_flush = 1'b1;
    pulse();
    msg_flush = 1'b0;
    step(WORDS + 2);
    check("flush_at_start_writes", 32'(wlog.size()), 32'd0);
    // Flush on the 4th word of the next burst.
    pulse();
    step(3);
    msg_flush = 1'b1;
    #1;
    check("flush_wr_comb", 32'(fifo_wr), 32'd0);
    step(1);
    msg_flush = 1'b0;
    check("flush_busy_after", 32'(busy), 32'd0);
    step(WORDS);
    check("flush_writes", 32'(wlog.size()), 32'd3);
    // Disabled scheduler never starts.
    enable = 1'b0;
    wlog.delete();
    for (int p = 0; p < 7; p++) begin
      pulse();
      step(2);
    end
    check("disabled_writes", 32'(wlog.size()), 32'd0);
    enable = 1'b1;

    // Reset in the middle of a burst.
    do_reset();
    fifo_usedw = 8'd250;
    pulse();
    step(3);
    fifo_usedw = 8'd0;
    pulse();
    step(4);
    check("pre_reset_skipped", 32'(frames_skipped), 32'd1);
    reset_n = 1'b0;
    step(1);
    check("midreset_fifo_wr", 32'(fifo_wr), 32'd0);
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_skipped", 32'(frames_skipped), 32'd0);
    reset_n = 1'b1;
    step(1);
    wlog.delete();
    pulse();
    step(WORDS + 2);
    check("post_reset_start_writes", 32'(wlog.size()), 32'(WORDS));

`ifdef BBOX_MSG_HEADER_EN
    // Header word and sequence numbering.
    do_reset();
    interval_cfg = 8'd1;
    pulse();
    step(WORDS + 2);
    check("hdr_burst1_writes", 32'(wlog.size()), 32'd13);
    if (wlog.size() > 0) check("hdr_burst1_header", wlog[0], 32'h42420006);
    wlog.delete();
    pulse();
    step(WORDS + 2);
    check("hdr_burst2_writes", 32'(wlog.size()), 32'd13);
    if (wlog.size() > 0) check("hdr_burst2_header", wlog[0], 32'h42420106);
    interval_cfg = 8'd0;
`endif

    step(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
